// File: rtl/sram_1rw1r_param.sv
`default_nettype none
// ============================================================================
// Module   : sram_1rw1r_param
// Purpose  : Parametrised single-clock 1RW + 1R SRAM model with post-reset
//            clear engine, write-first forwarding from port0 to port1,
//            out-of-range detection and registered read-valid strobes.
// Options  : define SRAM_PARITY_EN for per-lane even parity storage, the
//            perr output and the perr_inj input.
// Revision : 1.0 - initial release
// ============================================================================
module sram_1rw1r_param #(
   parameter int DATA_WIDTH = 32,
   parameter int LANE_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 256,
   parameter int NUM_WMASKS = DATA_WIDTH / LANE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  csb0,
   input  logic                  web0,
   input  logic [NUM_WMASKS-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   output logic [DATA_WIDTH-1:0] dout0,
   output logic                  dvld0,
   input  logic                  csb1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic [DATA_WIDTH-1:0] dout1,
   output logic                  dvld1,
   output logic                  oob,
   output logic                  ready
`ifdef SRAM_PARITY_EN
  ,input  logic                  perr_inj,
   output logic                  perr
`endif
);

   // Index width of the storage array; the array is rounded up to a power of
   // two so any truncated address is a legal index (only used when in range).
   localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int MEM_WORDS = 1 << IDX_W;
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_IDLE  = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [IDX_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   logic                  addr0_oob;
   logic                  addr1_oob;
   logic                  req0;
   logic                  wr0;
   logic                  rd0;
   logic                  rd1;
   logic                  collide;
   logic [IDX_W-1:0]      idx0;
   logic [IDX_W-1:0]      idx1;
   logic [DATA_WIDTH-1:0] bitmask;
   logic [DATA_WIDTH-1:0] rdata1;

   assign addr0_oob = ({1'b0, addr0} >= DEPTH_EXT);
   assign addr1_oob = ({1'b0, addr1} >= DEPTH_EXT);
   assign idx0      = addr0[IDX_W-1:0];
   assign idx1      = addr1[IDX_W-1:0];

   // Requests are only honoured once the clear engine has finished.
   assign req0    = ready & ~csb0;
   assign wr0     = req0 & ~web0 & ~addr0_oob;
   assign rd0     = req0 & web0;
   assign rd1     = ready & ~csb1;
   assign collide = wr0 & rd1 & ~addr1_oob & (addr0 == addr1);

   // Expand the lane mask to a per-bit mask for forwarding.
   for (genvar i = 0; i < NUM_WMASKS; i++) begin : g_lane_mask
      assign bitmask[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{wmask0[i]}};
   end

   // Write-first: port1 sees the lanes port0 is writing this very cycle.
   assign rdata1 = collide ? ((din0 & bitmask) | (mem[idx1] & ~bitmask))
                           : mem[idx1];

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_CLEAR;
      else     state <= state_nxt;
   end

   // Next state: leave CLEAR after the last word has been zeroed.
   always_comb begin
      state_nxt = state;
      if ((state == S_CLEAR) && (cnt == LAST_IDX)) state_nxt = S_IDLE;
   end

   // Clear counter walks every word once after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                         cnt <= '0;
      else if ((state == S_CLEAR) && (cnt == LAST_IDX)) cnt <= '0;
      else if (state == S_CLEAR)                        cnt <= cnt + 1'b1;
   end

   // ready mirrors the IDLE state, registered so it rises on the final clear edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ready <= 1'b0;
      else     ready <= (state_nxt == S_IDLE);
   end

   // Storage: clear engine has priority, otherwise masked port0 writes.
   always_ff @(posedge clk) begin
      if (state == S_CLEAR) begin
         mem[cnt] <= '0;
      end else if (wr0) begin
         for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) mem[idx0][i*LANE_WIDTH +: LANE_WIDTH] <= din0[i*LANE_WIDTH +: LANE_WIDTH];
         end
      end
   end

   // Port0 read data and valid strobe; out-of-range reads return zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout0 <= '0;
         dvld0 <= 1'b0;
      end else begin
         dvld0 <= rd0;
         if (rd0) dout0 <= addr0_oob ? '0 : mem[idx0];
      end
   end

   // Port1 read data and valid strobe with write-first forwarding.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout1 <= '0;
         dvld1 <= 1'b0;
      end else begin
         dvld1 <= rd1;
         if (rd1) dout1 <= addr1_oob ? '0 : rdata1;
      end
   end

   // Single out-of-range pulse even when both ports miss in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) oob <= 1'b0;
      else     oob <= (req0 & addr0_oob) | (rd1 & addr1_oob);
   end

`ifdef SRAM_PARITY_EN
   logic [NUM_WMASKS-1:0] pmem [MEM_WORDS];
   logic [NUM_WMASKS-1:0] wpar;
   logic [NUM_WMASKS-1:0] rpar0;
   logic [NUM_WMASKS-1:0] rpar1;
   logic [NUM_WMASKS-1:0] spar1;

   // Even parity per lane: write side (optionally corrupted) and read side.
   for (genvar i = 0; i < NUM_WMASKS; i++) begin : g_lane_par
      assign wpar[i]  = (^din0[i*LANE_WIDTH +: LANE_WIDTH]) ^ perr_inj;
      assign rpar0[i] = ^mem[idx0][i*LANE_WIDTH +: LANE_WIDTH];
      assign rpar1[i] = ^rdata1[i*LANE_WIDTH +: LANE_WIDTH];
   end

   // Stored parity seen by port1, forwarded alongside the data on a collision.
   assign spar1 = collide ? ((wpar & wmask0) | (pmem[idx1] & ~wmask0)) : pmem[idx1];

   // Parity storage follows the data array lane by lane.
   always_ff @(posedge clk) begin
      if (state == S_CLEAR) begin
         pmem[cnt] <= '0;
      end else if (wr0) begin
         for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) pmem[idx0][i] <= wpar[i];
         end
      end
   end

   // Parity error pulse accompanies an in-range read with a bad lane.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) perr <= 1'b0;
      else     perr <= (rd0 & ~addr0_oob & (|(rpar0 ^ pmem[idx0])))
                     | (rd1 & ~addr1_oob & (|(rpar1 ^ spar1)));
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw1r_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_1rw1r_param
// Purpose  : Directed, table-driven bench for sram_1rw1r_param
//            (DEPTH = 16, ADDR_WIDTH = 8, DATA_WIDTH = 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_1rw1r_param;

   logic        clk;
   logic        rst;
   logic        csb0;
   logic        web0;
   logic [3:0]  wmask0;
   logic [7:0]  addr0;
   logic [31:0] din0;
   logic [31:0] dout0;
   logic        dvld0;
   logic        csb1;
   logic [7:0]  addr1;
   logic [31:0] dout1;
   logic        dvld1;
   logic        oob;
   logic        ready;
`ifdef SRAM_PARITY_EN
   logic        perr_inj;
   logic        perr;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        csb0;
      logic        web0;
      logic [3:0]  wmask0;
      logic [7:0]  addr0;
      logic [31:0] din0;
      logic        csb1;
      logic [7:0]  addr1;
      logic [31:0] e_dout0;
      logic        e_dvld0;
      logic [31:0] e_dout1;
      logic        e_dvld1;
      logic        e_oob;
   } vec_t;

   localparam int NVEC = 15;
   vec_t vecs [NVEC];

   sram_1rw1r_param #(
      .DATA_WIDTH(32),
      .LANE_WIDTH(8),
      .ADDR_WIDTH(8),
      .DEPTH     (16)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .csb0    (csb0),
      .web0    (web0),
      .wmask0  (wmask0),
      .addr0   (addr0),
      .din0    (din0),
      .dout0   (dout0),
      .dvld0   (dvld0),
      .csb1    (csb1),
      .addr1   (addr1),
      .dout1   (dout1),
      .dvld1   (dvld1),
      .oob     (oob),
      .ready   (ready)
`ifdef SRAM_PARITY_EN
     ,.perr_inj(perr_inj),
      .perr    (perr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
      end
   endtask

   task automatic drive_idle();
      csb0   = 1'b1;
      web0   = 1'b1;
      wmask0 = 4'h0;
      addr0  = 8'd0;
      din0   = 32'h0;
      csb1   = 1'b1;
      addr1  = 8'd0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dout0"}, dout0, 32'h0);
      check({tag, "_dout1"}, dout1, 32'h0);
      check({tag, "_dvld0"}, {31'h0, dvld0}, 32'h0);
      check({tag, "_dvld1"}, {31'h0, dvld1}, 32'h0);
      check({tag, "_oob"},   {31'h0, oob},   32'h0);
      check({tag, "_ready"}, {31'h0, ready}, 32'h0);
   endtask

   initial begin
      //            csb0 web0 wm    a0     din0          csb1 a1     e_dout0       v0    e_dout1       v1    oob
      vecs[0]  = '{1'b0, 1'b0, 4'hF, 8'd5,   32'hDEADBEEF, 1'b1, 8'd0,   32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 4'h1, 8'd5,   32'h000000AA, 1'b1, 8'd0,   32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 4'h0, 8'd5,   32'h00000000, 1'b1, 8'd0,   32'hDEADBEAA, 1'b1, 32'h00000000, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 4'h0, 8'd0,   32'h00000000, 1'b1, 8'd0,   32'hDEADBEAA, 1'b0, 32'h00000000, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 4'hF, 8'd7,   32'hAAAAAAAA, 1'b0, 8'd5,   32'hDEADBEAA, 1'b0, 32'hDEADBEAA, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 4'hC, 8'd7,   32'h11223344, 1'b0, 8'd7,   32'hDEADBEAA, 1'b0, 32'h1122AAAA, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 4'h0, 8'd7,   32'h00000000, 1'b0, 8'd7,   32'h1122AAAA, 1'b1, 32'h1122AAAA, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 4'h0, 8'd7,   32'hFFFFFFFF, 1'b0, 8'd7,   32'h1122AAAA, 1'b0, 32'h1122AAAA, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 4'hF, 8'd20,  32'h12345678, 1'b1, 8'd0,   32'h1122AAAA, 1'b0, 32'h1122AAAA, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 4'h0, 8'd20,  32'h00000000, 1'b1, 8'd0,   32'h00000000, 1'b1, 32'h1122AAAA, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 4'h0, 8'd0,   32'h00000000, 1'b1, 8'd0,   32'h00000000, 1'b0, 32'h1122AAAA, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 4'h0, 8'd4,   32'h00000000, 1'b0, 8'd255, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 4'h0, 8'd16,  32'h00000000, 1'b0, 8'd200, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 4'h0, 8'd5,   32'h00000000, 1'b0, 8'd15,  32'hDEADBEAA, 1'b1, 32'h00000000, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 4'hF, 8'd15,  32'h0F0F0F0F, 1'b0, 8'd15,  32'hDEADBEAA, 1'b0, 32'h0F0F0F0F, 1'b1, 1'b0};

      rst = 1'b1;
      drive_idle();
`ifdef SRAM_PARITY_EN
      perr_inj = 1'b0;
`endif
      #2;
      check_reset_outputs("por");

      // Clear sequence after power-on reset: ready low for exactly 16 edges.
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         check($sformatf("clear1_ready_e%0d", i), {31'h0, ready}, {31'h0, (i == 16)});
      end

      // Every address reads back zero on both ports.
      for (int a = 0; a < 16; a++) begin
         @(negedge clk);
         csb0 = 1'b0; web0 = 1'b1; addr0 = 8'(a);
         csb1 = 1'b0; addr1 = 8'(15 - a);
         @(posedge clk); #1;
         check($sformatf("sweep%0d_dout0", a), dout0, 32'h0);
         check($sformatf("sweep%0d_dvld0", a), {31'h0, dvld0}, 32'h1);
         check($sformatf("sweep%0d_dout1", a), dout1, 32'h0);
         check($sformatf("sweep%0d_dvld1", a), {31'h0, dvld1}, 32'h1);
      end

      // Table-driven functional vectors.
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         csb0 = vecs[i].csb0; web0 = vecs[i].web0; wmask0 = vecs[i].wmask0;
         addr0 = vecs[i].addr0; din0 = vecs[i].din0;
         csb1 = vecs[i].csb1; addr1 = vecs[i].addr1;
         @(posedge clk); #1;
         check($sformatf("vec%0d_dout0", i), dout0, vecs[i].e_dout0);
         check($sformatf("vec%0d_dvld0", i), {31'h0, dvld0}, {31'h0, vecs[i].e_dvld0});
         check($sformatf("vec%0d_dout1", i), dout1, vecs[i].e_dout1);
         check($sformatf("vec%0d_dvld1", i), {31'h0, dvld1}, {31'h0, vecs[i].e_dvld1});
         check($sformatf("vec%0d_oob", i),   {31'h0, oob},   {31'h0, vecs[i].e_oob});
      end
      @(negedge clk);
      drive_idle();

      // Asynchronous reset while IDLE clears the registered outputs at once.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs("idle_rst");
      @(negedge clk);
      rst = 1'b0;

      // Requests during CLEAR must be ignored (write @3, out-of-range read).
      csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 8'd3; din0 = 32'hFFFFFFFF;
      csb1 = 1'b0; addr1 = 8'd200;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         check($sformatf("clr_ign_e%0d_dvld1", i), {31'h0, dvld1}, 32'h0);
         check($sformatf("clr_ign_e%0d_oob", i),   {31'h0, oob},   32'h0);
      end

      // Reset again at cnt = 8; the clear restarts from zero.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs("clear_rst");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         check($sformatf("clear2_ready_e%0d", i), {31'h0, ready}, {31'h0, (i == 16)});
         check($sformatf("clear2_e%0d_dvld0", i), {31'h0, dvld0}, 32'h0);
         check($sformatf("clear2_e%0d_dvld1", i), {31'h0, dvld1}, 32'h0);
         check($sformatf("clear2_e%0d_oob", i),   {31'h0, oob},   32'h0);
      end
      @(negedge clk);
      drive_idle();

      // Memory is clean again: no leaked write at 3, old data at 5 cleared.
      @(negedge clk);
      csb0 = 1'b0; web0 = 1'b1; addr0 = 8'd3;
      csb1 = 1'b0; addr1 = 8'd5;
      @(posedge clk); #1;
      check("post_clear_dout0", dout0, 32'h0);
      check("post_clear_dvld0", {31'h0, dvld0}, 32'h1);
      check("post_clear_dout1", dout1, 32'h0);
      check("post_clear_dvld1", {31'h0, dvld1}, 32'h1);
      @(negedge clk);
      drive_idle();

`ifdef SRAM_PARITY_EN
      // Corrupted parity on write is reported with the read strobe.
      @(negedge clk);
      csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 8'd3; din0 = 32'h12345678;
      perr_inj = 1'b1;
      @(negedge clk);
      perr_inj = 1'b0;
      web0 = 1'b1;
      @(posedge clk); #1;
      check("par_bad_perr",  {31'h0, perr},  32'h1);
      check("par_bad_dvld0", {31'h0, dvld0}, 32'h1);
      check("par_bad_dout0", dout0, 32'h12345678);
      @(negedge clk);
      drive_idle();
      @(posedge clk); #1;
      check("par_idle_perr", {31'h0, perr}, 32'h0);
      @(negedge clk);
      csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 8'd3; din0 = 32'h12345678;
      @(negedge clk);
      web0 = 1'b1;
      @(posedge clk); #1;
      check("par_good_perr",  {31'h0, perr},  32'h0);
      check("par_good_dvld0", {31'h0, dvld0}, 32'h1);
      @(negedge clk);
      drive_idle();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
